instr_encoder_loader: RTL

- Encodes mnemonic-level instruction requests (operation select + operand) into the 8-bit NAND-CPU instruction byte.
- Buffers the encoded bytes in a small FIFO and streams them into instruction memory at sequential addresses from 0.
- Acts as the inverse of the instruction decoder; used by the boot/program-load path and by test infrastructure.
- A load session begins on start and ends when HLT is written, or earlier on an error.

---
 rtl/instr_encoder_loader.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/instr_encoder_loader.sv
// rtl/instr_encoder_loader.sv - encodes mnemonic requests into NAND-CPU bytes and streams them into instruction memory
module instr_encoder_loader #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [5:0]        in_operand,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   instr_count
);

  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [1:0] S_ERROR = 2'd3;

  localparam logic [3:0] OP_LI  = 4'd9;
  localparam logic [3:0] OP_HLT = 4'd13;

  logic [1:0]       state;
  logic [7:0]       fifo_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   fifo_cnt;
  logic             hlt_queued;

  logic             fifo_full;
  logic             fifo_empty;
  logic             accept;
  logic             push;
  logic             pop;
  logic             at_top;
  logic [7:0]       enc_byte;
  logic             enc_illegal;
  logic [3:0]       v;
  logic [1:0]       s;

  assign v = in_operand[3:0];
  assign s = in_operand[5:4];

  // Upper nibble follows the opcode map: ops 2..8 sit one below their index,
  // ops 10..13 two above; LI is the only form carrying the shift field.
  always_comb begin
    enc_byte    = 8'h00;
    enc_illegal = 1'b0;
    case (in_op)
      4'd0: begin
        enc_byte    = 8'h00;
        enc_illegal = (in_operand != 6'd0);
      end
      4'd1: begin
        enc_byte    = {4'h0, v};
        enc_illegal = (v == 4'd0);
      end
      4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8:
        enc_byte = {in_op - 4'd1, v};
      4'd9:
        enc_byte = {2'b10, s, v};
      4'd10, 4'd11, 4'd12, 4'd13:
        enc_byte = {in_op + 4'd2, v};
      default:
        enc_illegal = 1'b1;
    endcase
    if (in_op != OP_LI && s != 2'd0) begin
      enc_illegal = 1'b1;
    end
  end

  assign fifo_full  = (fifo_cnt == (PTR_W+1)'(DEPTH));
  assign fifo_empty = (fifo_cnt == '0);

  assign in_ready  = (state == S_LOAD) && !fifo_full && !hlt_queued;
  assign mem_valid = (state == S_LOAD) && !fifo_empty;
  assign mem_data  = fifo_mem[rd_ptr];
  assign busy      = (state == S_LOAD);
  assign done      = (state == S_DONE);
  assign error     = (state == S_ERROR);

  assign accept = in_valid && in_ready;
  assign push   = accept && !enc_illegal;
  assign pop    = mem_valid && mem_ready;
  assign at_top = (mem_addr == {ADDR_W{1'b1}});

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      fifo_mem[wr_ptr] <= enc_byte;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_cnt    <= '0;
      hlt_queued  <= 1'b0;
      mem_addr    <= '0;
      instr_count <= '0;
      err_code    <= 2'd0;
    end else begin
      case (state)
        S_LOAD: begin
          if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
            if (in_op == OP_HLT) begin
              hlt_queued <= 1'b1;
            end
          end
          if (pop) begin
            rd_ptr      <= rd_ptr + PTR_W'(1);
            instr_count <= instr_count + (ADDR_W+1)'(1);
            if (!at_top) begin
              mem_addr <= mem_addr + ADDR_W'(1);
            end
          end
          fifo_cnt <= fifo_cnt + (PTR_W+1)'(push) - (PTR_W+1)'(pop);

          if (accept && enc_illegal) begin
            state    <= S_ERROR;
            err_code <= 2'd1;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
          end else if (pop && mem_data[7:4] == 4'hF) begin
            state <= S_DONE;
          end else if (pop && at_top) begin
            // Memory is full: abort rather than wrap over address 0.
            state    <= S_ERROR;
            err_code <= 2'd2;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
          end
        end
        default: begin
          if (start) begin
            state       <= S_LOAD;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_cnt    <= '0;
            hlt_queued  <= 1'b0;
            mem_addr    <= '0;
            instr_count <= '0;
            err_code    <= 2'd0;
          end
        end
      endcase
    end
  end

endmodule
